// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared frame-buffer geometry, pixel/address types and blitter states
package gfx_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef logic [15:0] pixel_t;
   typedef logic [19:0] fb_addr_t;

   localparam pixel_t TRANSPARENT = 16'h0000;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      WRITE,
      ADVANCE,
      DONE
   } blit_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// rtl/fb_addr_calc.sv - (bank, x, y) to frame-buffer address with on-screen flag
module fb_addr_calc
   import gfx_pkg::*;
(
   input  logic        bank,
   input  logic [10:0] x,
   input  logic [10:0] y,
   output fb_addr_t    addr,
   output logic        on_screen
);

   logic [18:0] lin;

   // y*640 as (y<<9)+(y<<7); only the low 9 bits of y matter once on_screen holds
   always_comb begin
      on_screen = (x < 11'(SCREEN_W)) && (y < 11'(SCREEN_H));
      lin       = {1'b0, y[8:0], 9'b0} + {3'b0, y[8:0], 7'b0} + {9'b0, x[9:0]};
      addr      = {bank, lin};
   end

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sprite ROM to back frame buffer copy engine; optional SPRITE_MIRROR_EN adds horizontal flip
module sprite_blitter
   import gfx_pkg::*;
#(
   parameter int SPRITE_W = 32,
   parameter int SPRITE_H = 32,
   parameter int NUM_IMG  = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [2:0]  img_id,
   input  logic [9:0]  imgX,
   input  logic [9:0]  imgY,
   input  logic        back_buffer,
`ifdef SPRITE_MIRROR_EN
   input  logic        mirror_x,
`endif
   output logic        Done,
   output logic        busy,
   output logic [12:0] rom_addr,
   input  logic [15:0] rom_data,
   output logic        wr_req,
   output logic [19:0] wr_addr,
   output logic [15:0] wr_data,
   input  logic        wr_ack
);

   localparam int CW = $clog2(SPRITE_W);
   localparam int RW = $clog2(SPRITE_H);
   localparam int IW = $clog2(NUM_IMG);

   blit_state_t     state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic [IW-1:0]   img_q, img_d;
   logic [9:0]      x0_q, x0_d;
   logic [9:0]      y0_q, y0_d;
   logic            bank_q, bank_d;
   logic            wr_req_q, wr_req_d;
   fb_addr_t        wr_addr_q, wr_addr_d;
   pixel_t          wr_data_q, wr_data_d;
   logic            done_q, done_d;
   logic [12:0]     rom_addr_q, rom_addr_d;
   logic [CW-1:0]   rom_col;

   logic [10:0]     pix_x, pix_y;
   fb_addr_t        pix_addr;
   logic            pix_on_screen;

   assign pix_x = {1'b0, x0_q} + 11'(col_q);
   assign pix_y = {1'b0, y0_q} + 11'(row_q);

   fb_addr_calc u_addr (
      .bank      (bank_q),
      .x         (pix_x),
      .y         (pix_y),
      .addr      (pix_addr),
      .on_screen (pix_on_screen)
   );

`ifdef SPRITE_MIRROR_EN
   logic mirror_q, mirror_d;

   // mirror flag captured with the other blit parameters at Start
   always_comb begin
      mirror_d = mirror_q;
      if (state_q == IDLE && Start) mirror_d = mirror_x;
   end

   // mirror flag register
   always_ff @(posedge Clk) begin
      if (Reset) mirror_q <= 1'b0;
      else       mirror_q <= mirror_d;
   end

   // SPRITE_W is a power of two, so SPRITE_W-1-col is just ~col
   assign rom_col = mirror_d ? ~col_d : col_d;
`else
   assign rom_col = col_d;
`endif

   // ROM address follows the next (row, col) so it is already presented during FETCH
   always_comb begin
      rom_addr_d = 13'({img_d, row_d, rom_col});
   end

   // next-state and datapath updates for the blit walk
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      img_d     = img_q;
      x0_d      = x0_q;
      y0_d      = y0_q;
      bank_d    = bank_q;
      wr_req_d  = wr_req_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = done_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               img_d   = img_id[IW-1:0];
               x0_d    = imgX;
               y0_d    = imgY;
               bank_d  = back_buffer;
               row_d   = '0;
               col_d   = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (rom_data == TRANSPARENT || !pix_on_screen) begin
               state_d = ADVANCE;
            end else begin
               wr_addr_d = pix_addr;
               wr_data_d = rom_data;
               wr_req_d  = 1'b1;
               state_d   = WRITE;
            end
         end
         WRITE: begin
            if (wr_ack) begin
               wr_req_d = 1'b0;
               state_d  = ADVANCE;
            end
         end
         ADVANCE: begin
            if (row_q == RW'(SPRITE_H - 1) && col_q == CW'(SPRITE_W - 1)) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               col_d = col_q + 1'b1;
               if (col_q == CW'(SPRITE_W - 1)) row_d = row_q + 1'b1;
               state_d = FETCH;
            end
         end
         DONE: begin
            if (!Start) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         img_q      <= '0;
         x0_q       <= '0;
         y0_q       <= '0;
         bank_q     <= 1'b0;
         wr_req_q   <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         rom_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         img_q      <= img_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         bank_q     <= bank_d;
         wr_req_q   <= wr_req_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
         rom_addr_q <= rom_addr_d;
      end
   end

   assign busy     = (state_q != IDLE) && (state_q != DONE);
   assign Done     = done_q;
   assign rom_addr = rom_addr_q;
   assign wr_req   = wr_req_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed self-checking bench for sprite_blitter
module tb_sprite_blitter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic [2:0]  img_id;
   logic [9:0]  imgX;
   logic [9:0]  imgY;
   logic        back_buffer;
   logic        Done;
   logic        busy;
   logic [12:0] rom_addr;
   logic [15:0] rom_data = 16'h0;
   logic        wr_req;
   logic [19:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ack = 1'b0;

   logic [15:0] rom_mem [0:8191];
   logic [19:0] addr_log [$];
   logic [15:0] data_log [$];

   int          checks = 0;
   int          errors = 0;
   int          ack_mode = 0;
   int          wait_cnt = 0;
   bit          pending = 1'b0;
   logic [19:0] hold_addr;
   logic [15:0] hold_data;
   int          cyc;
   int          mx;

   sprite_blitter dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .img_id      (img_id),
      .imgX        (imgX),
      .imgY        (imgY),
      .back_buffer (back_buffer),
`ifdef SPRITE_MIRROR_EN
      .mirror_x    (1'b0),
`endif
      .Done        (Done),
      .busy        (busy),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) rom_data <= rom_mem[rom_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // arbiter model: drive ack for the coming edge, then log accepted writes and check hold-stability
   always @(negedge Clk) begin
      if (ack_mode == 0) begin
         wr_ack = 1'b1;
      end else if (wr_req === 1'b1) begin
         if (wait_cnt == 5) begin
            wr_ack   = 1'b1;
            wait_cnt = 0;
         end else begin
            wr_ack   = 1'b0;
            wait_cnt++;
         end
      end else begin
         wr_ack   = 1'b0;
         wait_cnt = 0;
      end
      if (wr_req === 1'b1) begin
         if (pending) begin
            check("hold_addr", 32'(wr_addr), 32'(hold_addr));
            check("hold_data", 32'(wr_data), 32'(hold_data));
         end else begin
            pending   = 1'b1;
            hold_addr = wr_addr;
            hold_data = wr_data;
         end
         if (wr_ack) begin
            addr_log.push_back(wr_addr);
            data_log.push_back(wr_data);
            pending = 1'b0;
         end
      end else begin
         pending = 1'b0;
      end
   end

   task automatic start_blit(input logic [2:0] id, input logic [9:0] x, input logic [9:0] y, input logic bank);
      @(negedge Clk);
      img_id      = id;
      imgX        = x;
      imgY        = y;
      back_buffer = bank;
      Start       = 1'b1;
      addr_log.delete();
      data_log.delete();
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (Done !== 1'b1 && n < 12000) begin
         @(negedge Clk);
         n++;
      end
      check("done_reached", 32'(Done), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) rom_mem[i] = 16'h0000;
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 32; c++) begin
            rom_mem[r*32 + c]        = 16'hF800;
            rom_mem[1024 + r*32 + c] = ((r + c) % 2 == 1) ? 16'h0000 : (16'h1000 | 16'(r*32 + c));
            rom_mem[2048 + r*32 + c] = 16'h8000 | 16'(r*32 + c);
         end
      end

      Reset = 1'b1; Start = 1'b0; img_id = 3'd0; imgX = 10'd0; imgY = 10'd0; back_buffer = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_req", 32'(wr_req), 32'd0);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      Reset = 1'b0;

      // opaque sprite 0 at origin, ack always high
      start_blit(3'd0, 10'd0, 10'd0, 1'b0);
      @(negedge Clk);
      check("t1_busy", 32'(busy), 32'd1);
      wait_done(cyc);
      check("t1_cycles", 32'(cyc >= 3000 && cyc <= 4200), 32'd1);
      check("t1_busy_done", 32'(busy), 32'd0);
      check("t1_count", 32'(addr_log.size()), 32'd1024);
      for (int k = 0; k < addr_log.size(); k++) begin
         check("t1_addr", 32'(addr_log[k]), 32'((k / 32) * 640 + (k % 32)));
         check("t1_data", 32'(data_log[k]), 32'hF800);
      end
      Start = 1'b0;
      @(negedge Clk);
      check("t1_done_drop", 32'(Done), 32'd0);

      // checkerboard sprite 1 into bank 1
      start_blit(3'd1, 10'd0, 10'd0, 1'b1);
      wait_done(cyc);
      check("t2_count", 32'(addr_log.size()), 32'd512);
      check("t2_addr0", 32'(addr_log[0]), 32'h80000);
      check("t2_data0", 32'(data_log[0]), 32'h1000);
      check("t2_addr1", 32'(addr_log[1]), 32'h80002);
      check("t2_data1", 32'(data_log[1]), 32'h1002);
      for (int k = 0; k < addr_log.size(); k++) begin
         check("t2_bank", 32'(addr_log[k][19]), 32'd1);
         check("t2_nonzero", 32'(data_log[k] != 16'h0000), 32'd1);
      end
      Start = 1'b0;
      @(negedge Clk);

      // clipped at the bottom-right corner
      start_blit(3'd2, 10'd620, 10'd470, 1'b0);
      wait_done(cyc);
      check("t3_count", 32'(addr_log.size()), 32'd200);
      mx = 0;
      foreach (addr_log[k]) if (int'(addr_log[k]) > mx) mx = int'(addr_log[k]);
      check("t3_max_addr", 32'(mx), 32'd307199);
      check("t3_addr0", 32'(addr_log[0]), 32'd301420);
      check("t3_data0", 32'(data_log[0]), 32'h8000);
      check("t3_last_addr", 32'(addr_log[199]), 32'd307199);
      check("t3_last_data", 32'(data_log[199]), 32'h8133);
      Start = 1'b0;
      @(negedge Clk);

      // ack delayed five cycles per request
      ack_mode = 1;
      start_blit(3'd2, 10'd100, 10'd50, 1'b0);
      wait_done(cyc);
      ack_mode = 0;
      check("t4_count", 32'(addr_log.size()), 32'd1024);
      check("t4_addr33", 32'(addr_log[33]), 32'd32741);
      check("t4_data33", 32'(data_log[33]), 32'h8021);
      check("t4_last_addr", 32'(addr_log[1023]), 32'd51971);
      check("t4_last_data", 32'(data_log[1023]), 32'h83FF);

      // Start held high after Done must not retrigger
      repeat (20) @(negedge Clk);
      check("t5_done_held", 32'(Done), 32'd1);
      check("t5_busy_held", 32'(busy), 32'd0);
      check("t5_no_writes", 32'(addr_log.size()), 32'd1024);
      Start = 1'b0;
      @(negedge Clk);
      img_id = 3'd0; imgX = 10'd0; imgY = 10'd0; back_buffer = 1'b0;
      Start = 1'b1;
      addr_log.delete();
      data_log.delete();
      @(negedge Clk);
      check("t5_restart_busy", 32'(busy), 32'd1);

      // reset in the middle of the second blit
      cyc = 0;
      while (addr_log.size() < 100 && cyc < 1000) begin
         @(negedge Clk);
         cyc++;
      end
      check("t6_reach100", 32'(addr_log.size() >= 100), 32'd1);
      Reset = 1'b1;
      Start = 1'b0;
      @(negedge Clk);
      check("t6_wr_req", 32'(wr_req), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_done", 32'(Done), 32'd0);
      Reset = 1'b0;
      start_blit(3'd2, 10'd0, 10'd0, 1'b0);
      wait_done(cyc);
      check("t6_count", 32'(addr_log.size()), 32'd1024);
      check("t6_addr0", 32'(addr_log[0]), 32'd0);
      check("t6_data0", 32'(data_log[0]), 32'h8000);
      check("t6_last_addr", 32'(addr_log[1023]), 32'd19871);
      check("t6_last_data", 32'(data_log[1023]), 32'h83FF);
      Start = 1'b0;
      @(negedge Clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
